// File: rtl/frame_reader_pkg.sv
// Shared types for the SDRAM frame reader.
// FSM states, pixel bundle and the FIFO word-pair unpack helper.
package frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } state_t;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } pixel_t;

  // RD1 = {0,G[9:5],B}, RD2 = {0,G[4:0],R}
  function automatic pixel_t unpack_rgb(
    input logic [15:0] rd1,
    input logic [15:0] rd2
  );
    pixel_t p;
    p.r = rd2[9:0];
    p.g = {rd1[14:10], rd2[14:10]};
    p.b = rd1[9:0];
    return p;
  endfunction

endpackage

// File: rtl/frame_reader_unpack.sv
// Data stage: latch FIFO words one cycle after the read and unpack.
// FRAME_READER_TESTPAT_EN adds an 8-bar colour test pattern mux.
module frame_reader_unpack
  import frame_reader_pkg::*;
#(
  parameter int H_ACT = 640
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [15:0] rd1_data,
  input  logic [15:0] rd2_data,
  input  logic [11:0] pix_x,
  input  logic        tp,
  output logic        dval,
  output pixel_t      pix
);

  pixel_t nxt;

`ifdef FRAME_READER_TESTPAT_EN
  logic [2:0] bar;

  // Pick FIFO data or the vertical bar colour for this column
  always_comb begin
    bar = 3'((32'(pix_x) * 8) / H_ACT);
    if (tp) begin
      nxt.r = {10{bar[2]}};
      nxt.g = {10{bar[1]}};
      nxt.b = {10{bar[0]}};
    end else begin
      nxt = unpack_rgb(rd1_data, rd2_data);
    end
  end
`else
  logic unused_tp;
  assign unused_tp = ^{tp, pix_x};
  assign nxt = unpack_rgb(rd1_data, rd2_data);
`endif

  // Register the pixel when the read issued last cycle returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dval <= 1'b0;
      pix  <= '0;
    end else begin
      dval <= vld;
      if (vld) pix <= nxt;
    end
  end

endmodule

// File: rtl/sdram_frame_reader.sv
// Drains one frame from SDRAM read FIFOs RD1/RD2 into 10-bit RGB pixels.
// Optional test pattern: define FRAME_READER_TESTPAT_EN.
module sdram_frame_reader
  import frame_reader_pkg::*;
#(
  parameter int          H_ACT     = 640,
  parameter int          V_ACT     = 480,
  parameter logic [15:0] RD1_BASE  = 16'h0000,
  parameter logic [15:0] RD2_BASE  = 16'h0000,
  parameter logic [7:0]  BURST_LEN = 8'd128,
  parameter int          LOAD_CYC  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iFRAME_START,
  input  logic        iREQ,
  input  logic        iTESTPAT,
  input  logic [15:0] RD1_DATA,
  input  logic [15:0] RD2_DATA,
  output logic        RD1,
  output logic        RD2,
  output logic [15:0] RD1_ADDR,
  output logic [15:0] RD2_ADDR,
  output logic [15:0] RD1_MAX_ADDR,
  output logic [15:0] RD2_MAX_ADDR,
  output logic [7:0]  RD1_LENGTH,
  output logic [7:0]  RD2_LENGTH,
  output logic        RD1_LOAD,
  output logic        RD2_LOAD,
  output logic        RD1_CLK,
  output logic        RD2_CLK,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic        oDVAL,
  output logic [11:0] oX_Cont,
  output logic [15:0] oY_Cont,
  output logic [31:0] oFrame_Cont,
  output logic        oOVERRUN
);

  localparam int N_PIX = H_ACT * V_ACT;
  localparam int LW = $clog2(LOAD_CYC + 1);

  state_t        state, state_nxt;
  logic [LW-1:0] lcnt;
  logic [11:0]   x, x1;
  logic [15:0]   y, y1;
  logic          take, last, rd_gate;
  logic          v1, last1, tp1;
  pixel_t        pix;

  assign last = (x == 12'(H_ACT - 1)) && (y == 16'(V_ACT - 1));

`ifdef FRAME_READER_TESTPAT_EN
  assign rd_gate = take & ~iTESTPAT;
`else
  assign rd_gate = take;
`endif

  assign RD1          = rd_gate;
  assign RD2          = rd_gate;
  assign RD1_LOAD     = (state == LOAD);
  assign RD2_LOAD     = (state == LOAD);
  assign RD1_ADDR     = RD1_BASE;
  assign RD2_ADDR     = RD2_BASE;
  assign RD1_MAX_ADDR = RD1_BASE + 16'(N_PIX);
  assign RD2_MAX_ADDR = RD2_BASE + 16'(N_PIX);
  assign RD1_LENGTH   = BURST_LEN;
  assign RD2_LENGTH   = BURST_LEN;
  assign RD1_CLK      = clk;
  assign RD2_CLK      = clk;
  assign oRed         = pix.r;
  assign oGreen       = pix.g;
  assign oBlue        = pix.b;

  // Next state and read issue; frame start always wins
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    unique case (state)
      IDLE: if (iFRAME_START) state_nxt = LOAD;
      LOAD: begin
        if (iFRAME_START) state_nxt = LOAD;
        else if (lcnt == LW'(LOAD_CYC - 1)) state_nxt = STREAM;
      end
      STREAM: begin
        if (iFRAME_START) state_nxt = LOAD;
        else if (iREQ) begin
          take = 1'b1;
          if (last) state_nxt = DONE;
        end
      end
      DONE: if (iFRAME_START) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Load timer and x/y read position, cleared on frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt <= '0;
      x    <= '0;
      y    <= '0;
    end else if (iFRAME_START) begin
      lcnt <= '0;
      x    <= '0;
      y    <= '0;
    end else begin
      if (state == LOAD) lcnt <= lcnt + 1'b1;
      if (take) begin
        if (x == 12'(H_ACT - 1)) begin
          x <= '0;
          y <= y + 16'd1;
        end else begin
          x <= x + 12'd1;
        end
      end
    end
  end

  // Sticky overrun: request outside STREAM, cleared by a new load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oOVERRUN <= 1'b0;
    else if (iFRAME_START) oOVERRUN <= 1'b0;
    else if (iREQ && state != STREAM) oOVERRUN <= 1'b1;
  end

  // Position tags travel with the read to align with oDVAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      x1          <= '0;
      y1          <= '0;
      last1       <= 1'b0;
      tp1         <= 1'b0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oFrame_Cont <= '0;
    end else begin
      v1 <= take;
      if (take) begin
        x1    <= x;
        y1    <= y;
        last1 <= last;
        tp1   <= iTESTPAT;
      end
      if (v1) begin
        oX_Cont <= x1;
        oY_Cont <= y1;
        if (last1) oFrame_Cont <= oFrame_Cont + 32'd1;
      end
    end
  end

  frame_reader_unpack #(
    .H_ACT(H_ACT)
  ) u_unpack (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld     (v1),
    .rd1_data(RD1_DATA),
    .rd2_data(RD2_DATA),
    .pix_x   (x1),
    .tp      (tp1),
    .dval    (oDVAL),
    .pix     (pix)
  );

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Random-stimulus bench for sdram_frame_reader (H=4, V=2, 4 load cycles).
// Reference model works in whole-frame pixel indices, not x/y registers.
module tb_sdram_frame_reader;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int N  = H * V;
  localparam int LC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fs = 1'b0, req = 1'b0, tp = 1'b0;
  logic [15:0] d1 = '0, d2 = '0;
  logic        RD1, RD2, RD1_LOAD, RD2_LOAD, RD1_CLK, RD2_CLK;
  logic [15:0] RD1_ADDR, RD2_ADDR, RD1_MAX_ADDR, RD2_MAX_ADDR;
  logic [7:0]  RD1_LENGTH, RD2_LENGTH;
  logic [9:0]  oRed, oGreen, oBlue;
  logic        oDVAL, oOVERRUN;
  logic [11:0] oX_Cont;
  logic [15:0] oY_Cont;
  logic [31:0] oFrame_Cont;

  sdram_frame_reader #(
    .H_ACT(H), .V_ACT(V), .LOAD_CYC(LC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .iFRAME_START(fs), .iREQ(req), .iTESTPAT(tp),
    .RD1_DATA(d1), .RD2_DATA(d2),
    .RD1(RD1), .RD2(RD2),
    .RD1_ADDR(RD1_ADDR), .RD2_ADDR(RD2_ADDR),
    .RD1_MAX_ADDR(RD1_MAX_ADDR), .RD2_MAX_ADDR(RD2_MAX_ADDR),
    .RD1_LENGTH(RD1_LENGTH), .RD2_LENGTH(RD2_LENGTH),
    .RD1_LOAD(RD1_LOAD), .RD2_LOAD(RD2_LOAD),
    .RD1_CLK(RD1_CLK), .RD2_CLK(RD2_CLK),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oDVAL(oDVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
    .oFrame_Cont(oFrame_Cont), .oOVERRUN(oOVERRUN)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Model: phase 0 idle, 1 loading, 2 streaming, 3 frame done
  int          ph, lleft, n, p1_n, o_x, o_y;
  logic        ovr, p1_v, o_v;
  logic [31:0] frm;
  logic [9:0]  o_r, o_g, o_b;

  task automatic mreset();
    ph = 0; lleft = 0; n = 0; ovr = 1'b0; frm = '0;
    p1_v = 1'b0; p1_n = 0; o_v = 1'b0;
    o_x = 0; o_y = 0; o_r = '0; o_g = '0; o_b = '0;
  endtask

  task automatic cycle(input logic f, input logic r, input logic fixed);
    logic rd;
    fs = f;
    req = r;
    tp = 1'($urandom);
    if (fixed) begin
      d1 = 16'h2C0F;
      d2 = 16'h5433;
    end else begin
      d1 = 16'($urandom);
      d2 = 16'($urandom);
    end
    @(negedge clk);
    rd = (ph == 2) && r && !f;
    check("rd1", RD1, rd);
    check("rd2", RD2, rd);
    check("load1", RD1_LOAD, ph == 1);
    check("load2", RD2_LOAD, ph == 1);
    check("dval", oDVAL, o_v);
    check("overrun", oOVERRUN, ovr);
    check("frame", oFrame_Cont, frm);
    if (o_v) begin
      check("red", oRed, o_r);
      check("green", oGreen, o_g);
      check("blue", oBlue, o_b);
      check("x", oX_Cont, o_x);
      check("y", oY_Cont, o_y);
    end
    @(posedge clk);
    if (!rst_n) begin
      mreset();
    end else begin
      o_v = p1_v;
      if (p1_v) begin
        o_r = d2[9:0];
        o_g = {d1[14:10], d2[14:10]};
        o_b = d1[9:0];
        o_x = p1_n % H;
        o_y = p1_n / H;
        if (p1_n == N - 1) frm = frm + 1;
      end
      p1_v = rd;
      p1_n = n;
      if (f) ovr = 1'b0;
      else if (r && ph != 2) ovr = 1'b1;
      if (f) begin
        ph = 1; lleft = LC; n = 0;
      end else if (ph == 1) begin
        lleft--;
        if (lleft == 0) ph = 2;
      end else if (ph == 2 && rd) begin
        n++;
        if (n == N) ph = 3;
      end
    end
    #1;
  endtask

  task automatic zero_outs(input string pfx);
    check({pfx, "_dval"}, oDVAL, 0);
    check({pfx, "_red"}, oRed, 0);
    check({pfx, "_green"}, oGreen, 0);
    check({pfx, "_blue"}, oBlue, 0);
    check({pfx, "_x"}, oX_Cont, 0);
    check({pfx, "_y"}, oY_Cont, 0);
    check({pfx, "_frame"}, oFrame_Cont, 0);
    check({pfx, "_ovr"}, oOVERRUN, 0);
    check({pfx, "_rd1"}, RD1, 0);
    check({pfx, "_load"}, RD1_LOAD, 0);
  endtask

  initial begin
    mreset();
    repeat (3) cycle(1'($urandom), 1'($urandom), 1'b0);
    zero_outs("rst");
    rst_n = 1'b1;
    check("addr1", RD1_ADDR, 16'h0000);
    check("addr2", RD2_ADDR, 16'h0000);
    check("max1", RD1_MAX_ADDR, 16'd8);
    check("max2", RD2_MAX_ADDR, 16'd8);
    check("len1", RD1_LENGTH, 8'd128);
    check("len2", RD2_LENGTH, 8'd128);

    // one full frame of fixed data
    cycle(1'b1, 1'b0, 1'b1);
    repeat (LC) cycle(1'b0, 1'b0, 1'b1);
    repeat (N) cycle(1'b0, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    check("frame_one", oFrame_Cont, 1);

    // request after the frame is an overrun
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check("ovr_set", oOVERRUN, 1);

    // short frame aborted after 3 pixels
    cycle(1'b1, 1'b0, 1'b0);
    repeat (LC) cycle(1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (LC + 2) cycle(1'b0, 1'b0, 1'b0);
    check("abort_frame", oFrame_Cont, 1);
    repeat (N) cycle(1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check("frame_two", oFrame_Cont, 2);

    // random traffic
    repeat (800)
      cycle($urandom_range(0, 39) == 0, 1'($urandom), 1'b0);

    // async reset in the middle of a frame
    cycle(1'b1, 1'b0, 1'b0);
    repeat (LC) cycle(1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    zero_outs("arst");
    mreset();
    repeat (2) cycle(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (4) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (LC) cycle(1'b0, 1'b0, 1'b0);
    repeat (N) cycle(1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check("post_rst_frame", oFrame_Cont, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
